// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the 5-stage ARM core pipeline registers.
//   ARM_DATA_W      default width of PC and operand values
//   ARM_REG_ADDR_W  default register index width (16 architectural registers)
//   EXE_CMD_W       width of the ALU command field
//   exe_cmd_e       ALU command encodings produced by the decoder
//   id_ex_ctrl_t    decoded control bundle carried from ID into EXE
// -----------------------------------------------------------------------------
package arm_pkg;

    localparam int ARM_DATA_W     = 32;
    localparam int ARM_REG_ADDR_W = 4;
    localparam int EXE_CMD_W      = 4;

    typedef enum logic [EXE_CMD_W-1:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;

    typedef struct packed {
        logic                 wb_en;
        logic                 mem_r_en;
        logic                 mem_w_en;
        logic                 b;
        logic                 s;
        logic [EXE_CMD_W-1:0] exe_cmd;
    } id_ex_ctrl_t;

endpackage

// File: rtl/pipe_field_reg.sv
// -----------------------------------------------------------------------------
// pipe_field_reg
// Generic pipeline field register: clears to 0, holds, or loads.
//   W     field width
//   clk   rising-edge clock
//   rst   synchronous active-high reset (highest priority)
//   clr   synchronous clear (bubble insertion), overrides hold
//   hold  keep the current contents
//   d     next value
//   q     registered value
// -----------------------------------------------------------------------------
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         hold,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
// ID/EX pipeline register. Captures decoded control, operands and immediate
// fields from ID and presents them to EXE one cycle later.
//   Priority per edge: rst > flush > freeze > load.
//   flush loads a bubble (everything 0, ex_valid 0) even if freeze is high.
//   An invalid ID slot (id_valid=0) loads its side-effect control bits as 0
//   while data fields are still captured.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   freeze                      hazard stall, hold every field
//   flush                       branch taken, insert bubble
//   id_valid                    ID holds a real instruction
//   id_wb_en .. id_s            decoded control bits
//   id_exe_cmd                  ALU command
//   id_pc                       PC+4 of the instruction
//   id_val_rn, id_val_rm        register-file read values
//   id_imm, id_shift_operand,
//   id_signed_imm_24            immediate fields
//   id_dest, id_src1, id_src2   register indices
//   id_status                   NZCV snapshot
//   ex_*                        registered copies, including ex_valid
//
// Build option
//   ID_EX_FWD_SRC_EN  when defined, ex_src1/ex_src2 are registered for the
//                     forwarding unit; otherwise they are tied to 0.
// -----------------------------------------------------------------------------
module id_ex_pipe_reg
    import arm_pkg::*;
#(
    parameter int DATA_W     = ARM_DATA_W,
    parameter int REG_ADDR_W = ARM_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,

    input  logic                  id_valid,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    input  logic                  id_mem_w_en,
    input  logic                  id_b,
    input  logic                  id_s,
    input  logic [3:0]            id_exe_cmd,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [DATA_W-1:0]     id_val_rn,
    input  logic [DATA_W-1:0]     id_val_rm,
    input  logic                  id_imm,
    input  logic [11:0]           id_shift_operand,
    input  logic [23:0]           id_signed_imm_24,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic [3:0]            id_status,

    output logic                  ex_valid,
    output logic                  ex_wb_en,
    output logic                  ex_mem_r_en,
    output logic                  ex_mem_w_en,
    output logic                  ex_b,
    output logic                  ex_s,
    output logic [3:0]            ex_exe_cmd,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_val_rn,
    output logic [DATA_W-1:0]     ex_val_rm,
    output logic                  ex_imm,
    output logic [11:0]           ex_shift_operand,
    output logic [23:0]           ex_signed_imm_24,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic [REG_ADDR_W-1:0] ex_src1,
    output logic [REG_ADDR_W-1:0] ex_src2,
    output logic [3:0]            ex_status
);

    localparam int CTRL_W = 1 + $bits(id_ex_ctrl_t);
    localparam int OPND_W = 3 * DATA_W;
    localparam int IMMF_W = 1 + 12 + 24 + REG_ADDR_W + 4;

    // Side-effect bits are gated by id_valid so an invalid slot can never
    // write the register file, touch memory, branch or update flags.
    id_ex_ctrl_t id_ctrl;
    id_ex_ctrl_t ex_ctrl;

    always_comb begin
        id_ctrl          = '0;
        id_ctrl.wb_en    = id_wb_en    & id_valid;
        id_ctrl.mem_r_en = id_mem_r_en & id_valid;
        id_ctrl.mem_w_en = id_mem_w_en & id_valid;
        id_ctrl.b        = id_b        & id_valid;
        id_ctrl.s        = id_s        & id_valid;
        id_ctrl.exe_cmd  = id_exe_cmd;
    end

    // ---- ID -> EX boundary: control group ----
    pipe_field_reg #(.W(CTRL_W)) u_ctrl_reg (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .hold (freeze),
        .d    ({id_valid, id_ctrl}),
        .q    ({ex_valid, ex_ctrl})
    );

    assign ex_wb_en    = ex_ctrl.wb_en;
    assign ex_mem_r_en = ex_ctrl.mem_r_en;
    assign ex_mem_w_en = ex_ctrl.mem_w_en;
    assign ex_b        = ex_ctrl.b;
    assign ex_s        = ex_ctrl.s;
    assign ex_exe_cmd  = ex_ctrl.exe_cmd;

    // ---- ID -> EX boundary: operand group ----
    pipe_field_reg #(.W(OPND_W)) u_opnd_reg (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .hold (freeze),
        .d    ({id_pc, id_val_rn, id_val_rm}),
        .q    ({ex_pc, ex_val_rn, ex_val_rm})
    );

    // ---- ID -> EX boundary: immediate / index group ----
    pipe_field_reg #(.W(IMMF_W)) u_immf_reg (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .hold (freeze),
        .d    ({id_imm, id_shift_operand, id_signed_imm_24, id_dest, id_status}),
        .q    ({ex_imm, ex_shift_operand, ex_signed_imm_24, ex_dest, ex_status})
    );

`ifdef ID_EX_FWD_SRC_EN
    // ---- ID -> EX boundary: source indices for the forwarding unit ----
    pipe_field_reg #(.W(2 * REG_ADDR_W)) u_src_reg (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .hold (freeze),
        .d    ({id_src1, id_src2}),
        .q    ({ex_src1, ex_src2})
    );
`else
    // Forwarding disabled: no source-index flops, outputs constant 0.
    logic unused_src;
    assign unused_src = ^{id_src1, id_src2};
    assign ex_src1    = '0;
    assign ex_src2    = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe_reg
// Scoreboard bench for id_ex_pipe_reg: directed scenarios followed by random
// traffic. After each clock edge the driver pushes the value the EX side
// must show; a monitor on the falling edge pops and compares every field.
// -----------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        valid;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic [3:0]  exe_cmd;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  status;
    } io_t;

    logic clk = 1'b0;
    logic rst, freeze, flush;
    logic        id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s;
    logic [3:0]  id_exe_cmd;
    logic [31:0] id_pc, id_val_rn, id_val_rm;
    logic        id_imm;
    logic [11:0] id_shift_operand;
    logic [23:0] id_signed_imm_24;
    logic [3:0]  id_dest, id_src1, id_src2, id_status;
    logic        ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s;
    logic [3:0]  ex_exe_cmd;
    logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
    logic        ex_imm;
    logic [11:0] ex_shift_operand;
    logic [23:0] ex_signed_imm_24;
    logic [3:0]  ex_dest, ex_src1, ex_src2, ex_status;

    int n_cmp = 0;
    int n_err = 0;
    io_t sb[$];
    io_t model = '0;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .id_mem_w_en(id_mem_w_en), .id_b(id_b), .id_s(id_s),
        .id_exe_cmd(id_exe_cmd), .id_pc(id_pc), .id_val_rn(id_val_rn),
        .id_val_rm(id_val_rm), .id_imm(id_imm),
        .id_shift_operand(id_shift_operand), .id_signed_imm_24(id_signed_imm_24),
        .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2),
        .id_status(id_status),
        .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
        .ex_mem_w_en(ex_mem_w_en), .ex_b(ex_b), .ex_s(ex_s),
        .ex_exe_cmd(ex_exe_cmd), .ex_pc(ex_pc), .ex_val_rn(ex_val_rn),
        .ex_val_rm(ex_val_rm), .ex_imm(ex_imm),
        .ex_shift_operand(ex_shift_operand), .ex_signed_imm_24(ex_signed_imm_24),
        .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_status(ex_status)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: what EX must hold after an edge, given the
    // previous EX contents, the control inputs and the ID bundle.
    function automatic io_t next_ex(input io_t prev, input logic r, input logic fl,
                                    input logic fr, input io_t in);
        io_t n;
        if (r || fl) return '0;
        if (fr) return prev;
        n = in;
        if (!in.valid) begin
            n.wb_en    = 1'b0;
            n.mem_r_en = 1'b0;
            n.mem_w_en = 1'b0;
            n.b        = 1'b0;
            n.s        = 1'b0;
        end
`ifndef ID_EX_FWD_SRC_EN
        n.src1 = 4'h0;
        n.src2 = 4'h0;
`endif
        return n;
    endfunction

    function automatic io_t rand_io();
        io_t v;
        v.valid         = 1'($urandom);
        v.wb_en         = 1'($urandom);
        v.mem_r_en      = 1'($urandom);
        v.mem_w_en      = 1'($urandom);
        v.b             = 1'($urandom);
        v.s             = 1'($urandom);
        v.exe_cmd       = 4'($urandom);
        v.pc            = $urandom;
        v.val_rn        = $urandom;
        v.val_rm        = $urandom;
        v.imm           = 1'($urandom);
        v.shift_operand = 12'($urandom);
        v.signed_imm_24 = 24'($urandom);
        v.dest          = 4'($urandom);
        v.src1          = 4'($urandom);
        v.src2          = 4'($urandom);
        v.status        = 4'($urandom);
        return v;
    endfunction

    task automatic drive(input io_t v);
        id_valid = v.valid;       id_wb_en = v.wb_en;       id_mem_r_en = v.mem_r_en;
        id_mem_w_en = v.mem_w_en; id_b = v.b;               id_s = v.s;
        id_exe_cmd = v.exe_cmd;   id_pc = v.pc;             id_val_rn = v.val_rn;
        id_val_rm = v.val_rm;     id_imm = v.imm;           id_shift_operand = v.shift_operand;
        id_signed_imm_24 = v.signed_imm_24;                 id_dest = v.dest;
        id_src1 = v.src1;         id_src2 = v.src2;         id_status = v.status;
    endtask

    // One clock: apply inputs, let the edge happen, record the expectation.
    task automatic step(input logic r, input logic fl, input logic fr, input io_t in);
        rst = r; flush = fl; freeze = fr;
        drive(in);
        @(posedge clk);
        model = next_ex(model, r, fl, fr, in);
        sb.push_back(model);
        #1;
    endtask

    // Monitor: the register presents a new value every cycle.
    always @(negedge clk) begin
        io_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("valid",    64'(ex_valid),         64'(e.valid));
            check("wb_en",    64'(ex_wb_en),         64'(e.wb_en));
            check("mem_r_en", 64'(ex_mem_r_en),      64'(e.mem_r_en));
            check("mem_w_en", 64'(ex_mem_w_en),      64'(e.mem_w_en));
            check("b",        64'(ex_b),             64'(e.b));
            check("s",        64'(ex_s),             64'(e.s));
            check("exe_cmd",  64'(ex_exe_cmd),       64'(e.exe_cmd));
            check("pc",       64'(ex_pc),            64'(e.pc));
            check("val_rn",   64'(ex_val_rn),        64'(e.val_rn));
            check("val_rm",   64'(ex_val_rm),        64'(e.val_rm));
            check("imm",      64'(ex_imm),           64'(e.imm));
            check("shift",    64'(ex_shift_operand), 64'(e.shift_operand));
            check("simm24",   64'(ex_signed_imm_24), 64'(e.signed_imm_24));
            check("dest",     64'(ex_dest),          64'(e.dest));
            check("src1",     64'(ex_src1),          64'(e.src1));
            check("src2",     64'(ex_src2),          64'(e.src2));
            check("status",   64'(ex_status),        64'(e.status));
        end
    end

    initial begin
        io_t b;
        logic [3:0] exp_src1, exp_src2;
`ifdef ID_EX_FWD_SRC_EN
        exp_src1 = 4'hA;
        exp_src2 = 4'h3;
`else
        exp_src1 = 4'h0;
        exp_src2 = 4'h0;
`endif
        rst = 1'b1; flush = 1'b0; freeze = 1'b0;
        drive(rand_io());

        // Reset with garbage on the ID side.
        step(1'b1, 1'b0, 1'b0, rand_io());
        step(1'b1, 1'b0, 1'b0, rand_io());
        check("rst_valid", 64'(ex_valid), 64'd0);
        check("rst_pc",    64'(ex_pc),    64'd0);

        // Plain load.
        b = '0;
        b.valid = 1'b1; b.pc = 32'h0000_0008; b.val_rn = 32'h1234_5678;
        b.exe_cmd = 4'b0010; b.wb_en = 1'b1; b.src1 = 4'hA; b.src2 = 4'h3;
        step(1'b0, 1'b0, 1'b0, b);
        check("load_pc",     64'(ex_pc),      64'h8);
        check("load_val_rn", 64'(ex_val_rn),  64'h1234_5678);
        check("load_cmd",    64'(ex_exe_cmd), 64'h2);
        check("load_wb_en",  64'(ex_wb_en),   64'd1);
        check("load_valid",  64'(ex_valid),   64'd1);
        check("load_src1",   64'(ex_src1),    64'(exp_src1));
        check("load_src2",   64'(ex_src2),    64'(exp_src2));

        // Freeze for three cycles while ID moves on.
        for (int i = 0; i < 3; i++) begin
            b.pc = 32'h0000_000C + 32'(4 * i);
            step(1'b0, 1'b0, 1'b1, b);
            check("freeze_pc", 64'(ex_pc), 64'h8);
        end
        b.pc = 32'h0000_0018;
        step(1'b0, 1'b0, 1'b0, b);
        check("unfreeze_pc", 64'(ex_pc), 64'h18);

        // Flush wins over freeze.
        b.mem_w_en = 1'b1;
        step(1'b0, 1'b1, 1'b1, b);
        check("flush_mem_w_en", 64'(ex_mem_w_en), 64'd0);
        check("flush_valid",    64'(ex_valid),    64'd0);
        check("flush_pc",       64'(ex_pc),       64'd0);

        // Invalid slot: control gated, data captured.
        b = '0;
        b.wb_en = 1'b1; b.val_rm = 32'hDEAD_BEEF;
        step(1'b0, 1'b0, 1'b0, b);
        check("inv_wb_en",  64'(ex_wb_en),  64'd0);
        check("inv_val_rm", 64'(ex_val_rm), 64'hDEAD_BEEF);
        check("inv_valid",  64'(ex_valid),  64'd0);

        // Reset during freeze, then a normal load.
        b = rand_io();
        b.valid = 1'b1;
        step(1'b0, 1'b0, 1'b0, b);
        step(1'b0, 1'b0, 1'b1, rand_io());
        step(1'b1, 1'b0, 1'b1, rand_io());
        check("rst_frz_pc",    64'(ex_pc),    64'd0);
        check("rst_frz_valid", 64'(ex_valid), 64'd0);
        b = rand_io();
        b.valid = 1'b1;
        step(1'b0, 1'b0, 1'b0, b);
        check("post_rst_pc",    64'(ex_pc),    64'(b.pc));
        check("post_rst_valid", 64'(ex_valid), 64'd1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0),
                 rand_io());
        end

        // Let the monitor drain the last expectation.
        @(negedge clk);
        #1;
        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage ARM core; sits directly downstream of the ID-stage register file and decoder, feeding the EXE stage.
- Captures register operands, decoded control and immediate fields on each rising clk edge.
- Supports hazard freeze, branch flush, and a valid bit that marks bubbles.

Parameters:
- DATA_W, 32, width of PC and operand values
- REG_ADDR_W, 4, register index width (16 registers)

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous active-high reset
- freeze  in  1  hazard stall; hold all contents
- flush  in  1  branch taken; insert bubble
- id_valid  in  1  ID holds a real instruction
- id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s  in  1 each  decoded control bits
- id_exe_cmd  in  4  ALU command
- id_pc  in  DATA_W  PC+4 of instruction
- id_val_rn, id_val_rm  in  DATA_W  register-file read values
- id_imm  in  1  immediate-operand flag
- id_shift_operand  in  12  shifter operand field
- id_signed_imm_24  in  24  branch offset
- id_dest, id_src1, id_src2  in  REG_ADDR_W  register indices
- id_status  in  4  NZCV snapshot
- ex_* outputs  out  same widths  registered copies of every id_* input above, including ex_valid

Behaviour:
- Single always block on posedge clk. Priority: rst > flush > freeze > load.
- rst=1: every output is 0 on the next edge; ex_valid=0.
- flush=1 (with rst=0): next edge loads a bubble.
  - ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s = 0.
  - All data and index outputs = 0.
  - flush overrides a simultaneous freeze.
- freeze=1, flush=0: all outputs hold their previous values; no field updates.
- Otherwise: all ex_* = id_* after exactly 1 cycle of latency.
- Control gating: when id_valid=0 on a load, the control bits (wb_en, mem_r_en, mem_w_en, b, s) load as 0 and data fields load normally. No side effect can come from an invalid slot.
- Write-before-read ordering is the register file's job; this block captures id_val_rn/id_val_rm exactly as presented.
- No combinational input-to-output path.
- Reset mid-freeze or mid-flush: reset wins and the register is cleared.

Optional Feature:
- Macro: ID_EX_FWD_SRC_EN.
- Defined: ex_src1/ex_src2 are registered like the other fields, cleared on rst/flush and held on freeze, for the forwarding unit.
- Undefined: ex_src1/ex_src2 are tied to 0, no flops are inferred, and the forwarding unit is disabled.

Decomposition:
- Shared package arm_pkg holds: DATA_W and REG_ADDR_W defaults, the EXE_CMD width constant (4), the exe_cmd encodings, and a typedef id_ex_ctrl_t bundling wb_en, mem_r_en, mem_w_en, b, s and exe_cmd.
- One natural sub-module: pipe_field_reg, a generic width-parameterised flop with sync clear, hold enable and clear value 0. It is instantiated per field group (control, operands, immediates).

Test Plan:
- Load: rst=0 for 1 cycle, then id_pc=0x0000_0008, id_val_rn=0x1234_5678, id_exe_cmd=4'b0010, id_wb_en=1, id_valid=1 → next cycle ex_pc=0x8, ex_val_rn=0x12345678, ex_exe_cmd=2, ex_wb_en=1, ex_valid=1.
- Freeze: load as above, then freeze=1 for 3 cycles while id_pc changes to 0xC, 0x10, 0x14 → ex_pc stays 0x8 throughout; ex_pc=0x18 one cycle after freeze drops with id_pc=0x18.
- Flush plus freeze: flush=1 and freeze=1 in the same cycle with id_mem_w_en=1 → next cycle ex_mem_w_en=0, ex_valid=0, ex_pc=0.
- Invalid slot: id_valid=0, id_wb_en=1, id_val_rm=0xDEAD_BEEF → ex_wb_en=0, ex_val_rm=0xDEADBEEF, ex_valid=0.
- Mid-operation reset: rst=1 asserted during freeze → all ex_* = 0 at the next edge; a load after rst drops behaves normally.
- With and without the macro: id_src1=4'hA, id_src2=4'h3 → ex_src1=0xA and ex_src2=0x3 when ID_EX_FWD_SRC_EN is defined; 0 and 0 when it is undefined.
